// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The requester drives start and operands; the adder returns busy/done and the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: two cascaded half-adder cells per clock with the carry
// held in a flop; sum shifts in MSB-first so the first bit computed ends up at sum[0].
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | one bit pair consumed per clock, WIDTH clocks
// DONE  | one-cycle result strobe; start here restarts immediately
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra, rb, sum_q;
  logic             carry, cout_q;
  logic [CW-1:0]    cnt;
  logic             s1, c1, s, c2, carry_nxt, last, load;

  assign s1        = ra[0] ^ rb[0];
  assign c1        = ra[0] & rb[0];
  assign s         = s1 ^ carry;
  assign c2        = s1 & carry;
  assign carry_nxt = c1 | c2;
  assign last      = (cnt == LAST_BIT);
  // Start is only honoured outside RUN; requests during RUN are dropped.
  assign load      = bus.start && (state_q != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (load) begin
      ra     <= bus.a;
      rb     <= bus.b;
      carry  <= bus.cin;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (state_q == RUN) begin
      ra    <= ra >> 1;
      rb    <= rb >> 1;
      carry <= carry_nxt;
      sum_q <= {s, sum_q[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
      if (last) cout_q <= carry_nxt;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule
